// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer in front of a single-port data memory; DMEM_ARB_RR_EN selects round-robin.
// Latency: accept in T, memory access in T+1, response strobe in T+2; at most one access every 3 cycles.
// Backpressure: ready is raised only in IDLE and only to the winning port; the losing requester holds its request.
module dmem_arbiter #(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid_0_i,
    input  logic                req_valid_1_i,
    output logic                req_ready_0_o,
    output logic                req_ready_1_o,
    input  logic                req_we_0_i,
    input  logic                req_we_1_i,
    input  logic [AWIDTH-1:0]   req_addr_0_i,
    input  logic [AWIDTH-1:0]   req_addr_1_i,
    input  logic [DWIDTH-1:0]   req_wdata_0_i,
    input  logic [DWIDTH-1:0]   req_wdata_1_i,
    input  logic [1:0]          req_size_0_i,
    input  logic [1:0]          req_size_1_i,
    output logic                rsp_valid_0_o,
    output logic                rsp_valid_1_o,
    output logic [DWIDTH-1:0]   rsp_rdata_0_o,
    output logic [DWIDTH-1:0]   rsp_rdata_1_o,
    output logic                rsp_err_0_o,
    output logic                rsp_err_1_o,
    output logic [AWIDTH-1:0]   mem_addr_o,
    output logic [DWIDTH-1:0]   mem_wdata_o,
    output logic                mem_wen_o,
    output logic [DWIDTH/8-1:0] mem_wmask_o,
    input  logic [DWIDTH-1:0]   mem_rdata_i,
    output logic                busy_o
);
    localparam int MWIDTH = DWIDTH / 8;
    localparam logic [AWIDTH:0] ADDR_LIMIT = (AWIDTH + 1)'((2 ** AWIDTH) - 4);
    localparam bit DWORD_OK = (MWIDTH >= 8);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t                 state_q, state_d;
    logic                   port_q, port_d;
    logic                   we_q, we_d;
    logic [AWIDTH-1:0]      addr_q, addr_d;
    logic [DWIDTH-1:0]      wdata_q, wdata_d;
    logic [1:0]             size_q, size_d;
    logic                   err_q, err_d;
    logic [1:0][DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]             rsp_err_q, rsp_err_d;

    logic                   any_vld;
    logic                   gnt_port;
    logic                   sel_we;
    logic [AWIDTH-1:0]      sel_addr;
    logic [DWIDTH-1:0]      sel_wdata;
    logic [1:0]             sel_size;
    logic                   sel_err;

    // Mask is built at 8 bits and only then fitted to MWIDTH, after legality is decided.
    function automatic logic [MWIDTH-1:0] size_mask(input logic [1:0] size);
        logic [7:0] m8;
        case (size)
            2'b00:   m8 = 8'h01;
            2'b01:   m8 = 8'h03;
            2'b10:   m8 = 8'h0F;
            default: m8 = 8'hFF;
        endcase
        return MWIDTH'(m8);
    endfunction

    function automatic logic [DWIDTH-1:0] mask_bits(input logic [MWIDTH-1:0] m);
        logic [DWIDTH-1:0] bits;
        bits = '0;
        for (int i = 0; i < MWIDTH; i++) begin
            bits[i*8 +: 8] = {8{m[i]}};
        end
        return bits;
    endfunction

`ifdef DMEM_ARB_RR_EN
    logic last_q, last_d;
`endif

    always_comb begin
        any_vld = req_valid_0_i | req_valid_1_i;
`ifdef DMEM_ARB_RR_EN
        gnt_port = (req_valid_0_i && req_valid_1_i) ? ~last_q : ~req_valid_0_i;
`else
        gnt_port = ~req_valid_0_i;
`endif
        sel_we    = gnt_port ? req_we_1_i    : req_we_0_i;
        sel_addr  = gnt_port ? req_addr_1_i  : req_addr_0_i;
        sel_wdata = gnt_port ? req_wdata_1_i : req_wdata_0_i;
        sel_size  = gnt_port ? req_size_1_i  : req_size_0_i;
        sel_err   = (sel_we && (sel_addr[1:0] != 2'b00))
                 || ((sel_size == 2'b11) && !DWORD_OK)
                 || ({1'b0, sel_addr} > ADDR_LIMIT);
    end

    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        err_d       = err_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef DMEM_ARB_RR_EN
        last_d      = last_q;
`endif
        req_ready_0_o = 1'b0;
        req_ready_1_o = 1'b0;
        rsp_valid_0_o = 1'b0;
        rsp_valid_1_o = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        mem_wen_o     = 1'b0;
        mem_wmask_o   = '0;

        case (state_q)
            S_IDLE: begin
                if (any_vld) begin
                    req_ready_0_o = ~gnt_port;
                    req_ready_1_o = gnt_port;
                    port_d  = gnt_port;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    size_d  = sel_size;
                    err_d   = sel_err;
`ifdef DMEM_ARB_RR_EN
                    last_d  = gnt_port;
`endif
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_addr_o  = addr_q;
                mem_wdata_o = wdata_q;
                mem_wen_o   = we_q && !err_q;
                mem_wmask_o = we_q ? size_mask(size_q) : '0;
                // Load data is captured here so the response is registered in RESP.
                rsp_rdata_d[port_q] = (we_q || err_q) ? '0
                                    : (mem_rdata_i & mask_bits(size_mask(size_q)));
                rsp_err_d[port_q]   = err_q;
                state_d = S_RESP;
            end
            S_RESP: begin
                rsp_valid_0_o = ~port_q;
                rsp_valid_1_o = port_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            err_q       <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= '0;
`ifdef DMEM_ARB_RR_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            err_q       <= err_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef DMEM_ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign rsp_rdata_0_o = rsp_rdata_q[0];
    assign rsp_rdata_1_o = rsp_rdata_q[1];
    assign rsp_err_0_o   = rsp_err_q[0];
    assign rsp_err_1_o   = rsp_err_q[1];
    assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed cases plus random two-port traffic checked every cycle against a transaction model.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic v0 = 1'b0, v1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [7:0] a0 = '0, a1 = '0;
    logic [31:0] wd0 = '0, wd1 = '0;
    logic [1:0] s0 = '0, s1 = '0;
    logic r0, r1, rv0, rv1, re0, re1, mem_wen, busy;
    logic [31:0] rd0, rd1, mem_wdata, mem_rdata;
    logic [7:0] mem_addr;
    logic [3:0] mem_wmask;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0_i(v0), .req_valid_1_i(v1),
        .req_ready_0_o(r0), .req_ready_1_o(r1),
        .req_we_0_i(we0), .req_we_1_i(we1),
        .req_addr_0_i(a0), .req_addr_1_i(a1),
        .req_wdata_0_i(wd0), .req_wdata_1_i(wd1),
        .req_size_0_i(s0), .req_size_1_i(s1),
        .rsp_valid_0_o(rv0), .rsp_valid_1_o(rv1),
        .rsp_rdata_0_o(rd0), .rsp_rdata_1_o(rd1),
        .rsp_err_0_o(re0), .rsp_err_1_o(re1),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wen_o(mem_wen),
        .mem_wmask_o(mem_wmask), .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    // Word-organised memory behind the DUT; reads come from the word holding mem_addr.
    logic [31:0] tb_mem [64];
    assign mem_rdata = tb_mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_wen) begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) tb_mem[mem_addr[7:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end

    typedef struct { bit we; bit [7:0] addr; bit [31:0] wdata; bit [1:0] size; } req_t;
    req_t pq0[$], pq1[$];
    bit [31:0] ref_mem [64];

    int m_ph, m_port, m_last;
    req_t m_cur;
    bit m_err;
    bit [31:0] m_rd [2];
    bit m_re [2];
    bit acc0, acc1, rnd_en;
    int e_w, cyc, checks, errors;
    int grant_log[$];
    bit [31:0] last_rd [2];
    bit last_re [2];
    int rsp_cyc [2], acc_cyc [2];
    int wen_cnt, rsp_cnt;
    bit [3:0] last_wmask;
    bit [7:0] last_waddr;
    bit [31:0] last_wdata;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_err(input req_t r);
        return (r.we && (r.addr % 4 != 0)) || ((1 << r.size) > 4) || (int'(r.addr) > 256 - 4);
    endfunction

    function automatic bit [3:0] mask4(input bit [1:0] s);
        int bytes;
        bytes = 1 << s;
        return 4'((1 << bytes) - 1);
    endfunction

    function automatic bit [31:0] size_bits(input bit [1:0] s);
        bit [63:0] one;
        one = 64'd1;
        return 32'((one << (8 << s)) - 64'd1);
    endfunction

    function automatic int pick(input bit va, input bit vb);
        if (va && vb) begin
`ifdef DMEM_ARB_RR_EN
            return (m_last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        if (va) return 0;
        if (vb) return 1;
        return -1;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.we    = 1'($urandom_range(0, 1));
        r.size  = 2'($urandom_range(0, 3));
        r.wdata = $urandom;
        if ($urandom_range(0, 9) == 0) r.addr = 8'($urandom_range(240, 255));
        else r.addr = 8'($urandom_range(0, 15) * 4 + (($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0));
        return r;
    endfunction

    // Model advances at each falling edge; inputs change just after rising edges.
    always begin
        @(negedge clk);
        cyc++;
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (!rst_n) begin
            m_ph = 0; m_last = 1;
            m_rd[0] = '0; m_rd[1] = '0; m_re[0] = 1'b0; m_re[1] = 1'b0;
            chk("rst_ctrl", {busy, mem_wen, mem_wmask, rv0, rv1, re0, re1}, '0);
            chk("rst_data", {mem_addr, mem_wdata, rd0, rd1}, '0);
        end else begin
            e_w = (m_ph == 0) ? pick(v0, v1) : -1;
            chk("busy", busy, m_ph != 0);
            chk("ready", {r0, r1}, {e_w == 0, e_w == 1});
            if (m_ph == 1)
                chk("mem_access", {mem_wen, mem_wmask, mem_addr, mem_wdata},
                    {m_cur.we && !m_err, m_cur.we ? mask4(m_cur.size) : 4'h0, m_cur.addr, m_cur.wdata});
            else
                chk("mem_quiet", {mem_wen, mem_wmask, mem_addr, mem_wdata}, '0);
            chk("rsp0", {rv0, re0, rd0}, {m_ph == 2 && m_port == 0, m_re[0], m_rd[0]});
            chk("rsp1", {rv1, re1, rd1}, {m_ph == 2 && m_port == 1, m_re[1], m_rd[1]});
            if (v0 && r0) grant_log.push_back(0);
            if (v1 && r1) grant_log.push_back(1);
            if (mem_wen) begin
                wen_cnt++; last_wmask = mem_wmask; last_waddr = mem_addr; last_wdata = mem_wdata;
            end
            if (rv0) begin last_rd[0] = rd0; last_re[0] = re0; rsp_cyc[0] = cyc; rsp_cnt++; end
            if (rv1) begin last_rd[1] = rd1; last_re[1] = re1; rsp_cyc[1] = cyc; rsp_cnt++; end
            if (m_ph == 2) begin
                m_ph = 0;
            end else if (m_ph == 1) begin
                if (m_err || m_cur.we) m_rd[m_port] = '0;
                else m_rd[m_port] = ref_mem[m_cur.addr >> 2] & size_bits(m_cur.size);
                m_re[m_port] = m_err;
                if (m_cur.we && !m_err)
                    for (int b = 0; b < (1 << m_cur.size); b++)
                        ref_mem[m_cur.addr >> 2][b*8 +: 8] = m_cur.wdata[b*8 +: 8];
                m_ph = 2;
            end else if (e_w >= 0) begin
                m_cur  = (e_w == 0) ? pq0[0] : pq1[0];
                m_err  = model_err(m_cur);
                m_port = e_w;
                m_last = e_w;
                acc_cyc[e_w] = cyc;
                if (e_w == 0) acc0 = 1'b1; else acc1 = 1'b1;
                m_ph = 1;
            end
        end
        @(posedge clk);
        #1;
        if (acc0) void'(pq0.pop_front());
        if (acc1) void'(pq1.pop_front());
        if (rnd_en) begin
            if (pq0.size() < 2 && $urandom_range(0, 2) == 0) pq0.push_back(rand_req());
            if (pq1.size() < 2 && $urandom_range(0, 2) == 0) pq1.push_back(rand_req());
        end
        v0 = (pq0.size() > 0);
        v1 = (pq1.size() > 0);
        if (v0) begin we0 = pq0[0].we; a0 = pq0[0].addr; wd0 = pq0[0].wdata; s0 = pq0[0].size; end
        else begin we0 = 1'b0; a0 = '0; wd0 = '0; s0 = '0; end
        if (v1) begin we1 = pq1[0].we; a1 = pq1[0].addr; wd1 = pq1[0].wdata; s1 = pq1[0].size; end
        else begin we1 = 1'b0; a1 = '0; wd1 = '0; s1 = '0; end
    end

    task automatic issue(input int p, input bit we, input bit [7:0] addr, input bit [31:0] wdata, input bit [1:0] size);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wdata; r.size = size;
        if (p == 0) pq0.push_back(r); else pq1.push_back(r);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((pq0.size() != 0 || pq1.size() != 0 || m_ph != 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: traffic still pending after %0d cycles", n);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int n, w0, r_before;
        int exp_g [4];
        for (int i = 0; i < 64; i++) begin
            tb_mem[i] = $urandom;
            ref_mem[i] = tb_mem[i];
        end
        repeat (3) @(posedge clk);
        #3;
        chk("reset_state", {busy, r0, r1, rv0, rv1, re0, re1, mem_wen, mem_wmask, mem_addr}, '0);
        chk("reset_rdata", {rd0, rd1, mem_wdata}, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        issue(0, 1'b1, 8'h10, 32'hDEADBEEF, 2'b10); drain();
        chk("st_word_wen_count", wen_cnt, 1);
        chk("st_word_mask", last_wmask, 4'hF);
        chk("st_word_addr_data", {last_waddr, last_wdata}, {8'h10, 32'hDEADBEEF});
        issue(0, 1'b0, 8'h10, 32'h0, 2'b10); drain();
        chk("ld_word_rdata", {last_re[0], last_rd[0]}, {1'b0, 32'hDEADBEEF});
        chk("ld_word_latency", rsp_cyc[0] - acc_cyc[0], 2);
        issue(0, 1'b0, 8'h10, 32'h0, 2'b00); drain();
        chk("ld_byte_rdata", last_rd[0], 32'h000000EF);
        issue(0, 1'b1, 8'h14, 32'h1234, 2'b01); drain();
        chk("st_half_mask", {last_waddr, last_wmask}, {8'h14, 4'h3});
        chk("st_half_wen_count", wen_cnt, 2);
        issue(0, 1'b0, 8'h14, 32'h0, 2'b01); drain();
        chk("ld_half_rdata", last_rd[0], 32'h00001234);

        n = wen_cnt;
        issue(0, 1'b1, 8'h12, 32'h55, 2'b10); drain();
        chk("st_misaligned_nowrite", wen_cnt, n);
        chk("st_misaligned_rsp", {last_re[0], last_rd[0]}, {1'b1, 32'h0});
        issue(0, 1'b0, 8'hFE, 32'h0, 2'b00); drain();
        chk("ld_oob_err", last_re[0], 1'b1);
        issue(0, 1'b0, 8'h10, 32'h0, 2'b11); drain();
        chk("ld_dword_err", {last_re[0], last_rd[0]}, {1'b1, 32'h0});
        issue(0, 1'b0, 8'hFC, 32'h0, 2'b00); drain();
        chk("ld_last_legal_err", last_re[0], 1'b0);
        issue(0, 1'b0, 8'hFD, 32'h0, 2'b00); drain();
        chk("ld_first_oob_err", last_re[0], 1'b1);
        issue(0, 1'b0, 8'h11, 32'h0, 2'b00); drain();
        chk("ld_unaligned_ok", last_re[0], 1'b0);
        issue(1, 1'b0, 8'h10, 32'h0, 2'b10); drain();
        chk("p1_ld_word", {last_re[1], last_rd[1]}, {1'b0, 32'hDEADBEEF});
        chk("p1_latency", rsp_cyc[1] - acc_cyc[1], 2);

        // Both ports saturated straight after reset.
        pulse_reset();
        grant_log.delete();
        for (int i = 0; i < 4; i++) begin
            issue(0, 1'b1, 8'(8'h40 + 4 * i), 32'(i), 2'b10);
            issue(1, 1'b1, 8'(8'h80 + 4 * i), 32'(32'h100 + i), 2'b10);
        end
        drain();
`ifdef DMEM_ARB_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        chk("grant_total", grant_log.size(), 8);
        for (int i = 0; i < 4; i++)
            chk($sformatf("grant_%0d", i), (i < grant_log.size()) ? grant_log[i] : -1, exp_g[i]);
        for (int i = 0; i < 4; i++) begin
            issue(1, 1'b0, 8'(8'h80 + 4 * i), 32'h0, 2'b10); drain();
            chk($sformatf("p1_data_kept_%0d", i), last_rd[1], 32'h100 + i);
        end

        // Store interrupted by reset while in its memory cycle.
        issue(0, 1'b1, 8'h20, 32'hCAFEF00D, 2'b10); drain();
        issue(0, 1'b1, 8'h20, 32'h11223344, 2'b10);
        n = 0;
        while (m_ph != 1 && n < 50) begin @(posedge clk); n++; end
        #2;
        chk("midrst_wen_before", {mem_wen, mem_addr}, {1'b1, 8'h20});
        r_before = rsp_cnt;
        w0 = wen_cnt;
        rst_n = 1'b0;
        #1;
        chk("midrst_wen_drop", {mem_wen, busy}, 2'b00);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_no_rsp", rsp_cnt, r_before);
        chk("midrst_no_write", wen_cnt, w0);
        chk("post_rst_outputs", {busy, r0, r1, rv0, rv1, re0, re1, mem_wen, mem_wmask, mem_addr, rd0, rd1}, '0);
        @(posedge clk);
        #2;
        issue(0, 1'b0, 8'h20, 32'h0, 2'b10); drain();
        chk("midrst_prior_contents", last_rd[0], 32'hCAFEF00D);

        rnd_en = 1'b1;
        repeat (3000) @(posedge clk);
        rnd_en = 1'b0;
        #2;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester controller in front of the single-port data memory.
- Port 0 is the core load/store unit; port 1 is the debug/program-loader port.
- Arbitrates between the two ports, converts access size to the memory byte mask, and rejects illegal accesses.
- Sequences each access through a fixed 3-state FSM and returns a registered response to the granted port.

Parameters:
- AWIDTH, 8, memory byte-address width.
- DWIDTH, 32, memory data width; must be a multiple of 8.
- MWIDTH, DWIDTH/8 (localparam), number of byte-mask bits.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid_i[p]  in  1  request valid, p = 0,1 (two separate ports per signal).
- req_ready_o[p]  out  1  request accepted when valid and ready are both high.
- req_we_i[p]  in  1  1 = store, 0 = load.
- req_addr_i[p]  in  AWIDTH  byte address.
- req_wdata_i[p]  in  DWIDTH  store data, LSB-aligned.
- req_size_i[p]  in  2  00 byte, 01 half, 10 word, 11 dword.
- rsp_valid_o[p]  out  1  one-cycle response strobe.
- rsp_rdata_o[p]  out  DWIDTH  load data, zero-extended to size.
- rsp_err_o[p]  out  1  access rejected.
- mem_addr_o  out  AWIDTH  memory address.
- mem_wdata_o  out  DWIDTH  memory write data.
- mem_wen_o  out  1  memory write enable.
- mem_wmask_o  out  MWIDTH  memory byte mask.
- mem_rdata_i  in  DWIDTH  memory read data, combinational from mem_addr_o.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, rst_n low): state = IDLE; all outputs 0; latched request cleared; round-robin pointer set to "last grant = port 1".
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready_o is asserted combinationally to the winning port only; the other port's ready is 0.
  - If no request is valid: both readies 0, stay in IDLE.
  - On handshake: latch port id, we, addr, wdata, size; compute err; go to ACCESS.
- ACCESS:
  - mem_addr_o = latched addr; mem_wdata_o = latched wdata.
  - mem_wmask_o = size mask for stores; 0 for loads.
  - mem_wen_o = we && !err, high for exactly this one cycle.
  - For loads, mem_rdata_i is captured at the end of the cycle.
  - Go to RESP.
- RESP:
  - rsp_valid_o[granted] = 1 for exactly one cycle.
  - rsp_err_o = err.
  - rsp_rdata_o = captured data AND the size byte mask, expanded to bits. Returns 0 for stores and for errors.
  - Go to IDLE.
- Response outputs hold their values until the next RESP or reset; consumers sample only while rsp_valid_o is high.
- Latency and throughput:
  - Accept in cycle T, memory access in T+1, response in T+2.
  - Next accept no earlier than T+3; maximum throughput is 1 access per 3 cycles.
- Size to mask mapping: 00→1, 01→3, 10→15, 11→255. The result is truncated to MWIDTH bits only after the legality check.
- Error conditions (any one sets err; no memory write occurs):
  - store with addr[1:0] != 0;
  - size 11 while MWIDTH < 8;
  - addr > 2**AWIDTH - 4.
- Loads are not alignment-checked; the out-of-bound and size checks still apply.
- When not in ACCESS: mem_addr_o = 0, mem_wdata_o = 0, mem_wen_o = 0, mem_wmask_o = 0.
- A memory write is never issued with mem_wmask_o = 0.
- Arbitration with both ports valid in IDLE: port 0 wins by default; see Optional Feature.
- A request that is not granted is held by its requester (valid stays high and its fields stay stable); the arbiter requires this.
- Reset mid-transaction: the transaction is dropped, no rsp_valid is issued, and a write that was in ACCESS is suppressed because mem_wen_o drops asynchronously.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration: on contention, grant the port not granted last.
  - The pointer updates on every handshake.
  - After reset port 0 wins the first contention.
- Undefined:
  - Fixed priority, port 0 always wins; the pointer register is not built.
  - Port 1 can starve under continuous port 0 traffic.

Test Plan:
- Word store then load:
  - port0 store addr=0x10, wdata=0xDEADBEEF, size=10 → ACCESS cycle shows mem_wen_o=1, mask=0xF.
  - port0 load addr=0x10 → rsp_rdata_o[0]=0xDEADBEEF with rsp_valid_o[0] 2 cycles after accept, err=0.
- Byte load:
  - load addr=0x10, size=00 → rsp_rdata_o=0x000000EF.
  - store size=01, wdata=0x1234 → mask=0x3.
- Misaligned and out-of-bound:
  - store addr=0x12 → mem_wen_o stays 0; rsp_err_o=1; rdata=0.
  - load addr=0xFE (AWIDTH=8) → rsp_err_o=1.
  - size=11 with DWIDTH=32 → rsp_err_o=1.
- Contention, both ports valid continuously for 4 transactions:
  - without DMEM_ARB_RR_EN → grants 0,0,0,0;
  - with DMEM_ARB_RR_EN → grants 0,1,0,1, and port1 data is never lost.
- Reset mid-access:
  - rst_n low during ACCESS of a store to 0x20 → mem_wen_o drops immediately; no rsp_valid; a later load of 0x20 returns the prior contents.
  - After release: busy_o=0 and all outputs 0.
